// File: rtl/pc_watch_monitor.sv
// Retired-instruction counter with N programmable PC watchpoints (start/stop/error).
// Optional build macro PCMON_TID_FILTER_EN adds a per-watch thread-ID filter.
package pc_watch_pkg;
    typedef struct packed {
        logic clk;
    } iu_clk_type;
endpackage

module pc_watch_monitor
    import pc_watch_pkg::*;
#(
    parameter int NWATCH    = 4,
    parameter int CNTW      = 32,
    parameter int TIDW      = 6,
    parameter int AUTOSTART = 1,
    localparam int IDXW     = (NWATCH > 1) ? $clog2(NWATCH) : 1
) (
    input  iu_clk_type        gclk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [29:0]       commit_pc,
    input  logic [TIDW-1:0]   commit_tid,
    input  logic              cfg_we,
    input  logic [IDXW-1:0]   cfg_idx,
    input  logic [29:0]       cfg_pc,
    input  logic [1:0]        cfg_mode,
    input  logic [TIDW-1:0]   cfg_tid,
    input  logic              clr,
    output logic [CNTW-1:0]   count,
    output logic              running,
    output logic              done,
    output logic              error,
    output logic [NWATCH-1:0] hit,
    output logic              overflow
);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_START = 2'd1;
    localparam logic [1:0] M_STOP  = 2'd2;
    localparam logic [1:0] M_ERROR = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam state_t INIT = (AUTOSTART != 0) ? RUN : IDLE;

    logic clk;
    assign clk = gclk.clk;

    logic [29:0] wpc  [NWATCH];
    logic [1:0]  wmode[NWATCH];
`ifdef PCMON_TID_FILTER_EN
    logic [TIDW-1:0] wtid[NWATCH];
`else
    logic unused_tid;
    assign unused_tid = ^{commit_tid, cfg_tid};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NWATCH; i++) begin
                wpc[i]   <= '0;
                wmode[i] <= M_OFF;
`ifdef PCMON_TID_FILTER_EN
                wtid[i]  <= '0;
`endif
            end
        end else if (cfg_we) begin
            // Indices beyond NWATCH select nothing and are dropped.
            for (int i = 0; i < NWATCH; i++) begin
                if (cfg_idx == IDXW'(i)) begin
                    wpc[i]   <= cfg_pc;
                    wmode[i] <= cfg_mode;
`ifdef PCMON_TID_FILTER_EN
                    wtid[i]  <= cfg_tid;
`endif
                end
            end
        end
    end

    logic [NWATCH-1:0] match;
    logic              any_start;
    logic              any_stop;
    logic              any_err;

    always_comb begin
        match     = '0;
        any_start = 1'b0;
        any_stop  = 1'b0;
        any_err   = 1'b0;
        for (int i = 0; i < NWATCH; i++) begin
            match[i] = commit_valid && (wmode[i] != M_OFF)
                       && (commit_pc == wpc[i]);
`ifdef PCMON_TID_FILTER_EN
            match[i] = match[i] && (commit_tid == wtid[i]);
`endif
            if (match[i] && wmode[i] == M_START) any_start = 1'b1;
            if (match[i] && wmode[i] == M_STOP)  any_stop  = 1'b1;
            if (match[i] && wmode[i] == M_ERROR) any_err   = 1'b1;
        end
    end

    state_t state;
    logic   count_en;

    // The commit that starts or stops the run is itself counted.
    assign count_en = commit_valid
                      && (state == RUN || (state == IDLE && any_start));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            count    <= '0;
            error    <= 1'b0;
            hit      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            state    <= INIT;
            count    <= '0;
            error    <= 1'b0;
            hit      <= '0;
            overflow <= 1'b0;
        end else if (commit_valid) begin
            hit <= hit | match;
            if (any_err) error <= 1'b1;
            if (count_en) begin
                if (&count) overflow <= 1'b1;
                else        count    <= count + CNTW'(1);
            end
            unique case (state)
                IDLE: if (any_start) state <= any_stop ? DONE : RUN;
                RUN:  if (any_stop)  state <= DONE;
                DONE: state <= DONE;
                default: state <= INIT;
            endcase
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_pc_watch_monitor.sv
// Directed bench for pc_watch_monitor: one default instance (AUTOSTART=1, CNTW=32)
// and one small instance (AUTOSTART=0, CNTW=8) sharing the same stimulus.
module tb_pc_watch_monitor;
    import pc_watch_pkg::*;

    localparam logic [29:0] PC_STOP0 = 30'h9CD;  // 0x2734 >> 2
    localparam logic [29:0] PC_START = 30'h400;  // 0x1000 >> 2
    localparam logic [29:0] PC_STOP  = 30'h800;  // 0x2000 >> 2
    localparam logic [29:0] PC_ERR   = 30'h488;  // 0x1220 >> 2
    localparam logic [29:0] PC_NEW   = 30'hC00;  // 0x3000 >> 2
    localparam logic [29:0] PC_TID   = 30'h500;

    logic       clk;
    iu_clk_type gclk;
    assign gclk.clk = clk;

    logic        rst;
    logic        commit_valid;
    logic [29:0] commit_pc;
    logic [5:0]  commit_tid;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [29:0] cfg_pc;
    logic [1:0]  cfg_mode;
    logic [5:0]  cfg_tid;
    logic        clr;

    logic [31:0] count_a;
    logic        running_a, done_a, error_a, overflow_a;
    logic [3:0]  hit_a;
    logic [7:0]  count_b;
    logic        running_b, done_b, error_b, overflow_b;
    logic [3:0]  hit_b;

    pc_watch_monitor dut_a (
        .gclk(gclk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_tid(commit_tid),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
        .cfg_mode(cfg_mode), .cfg_tid(cfg_tid), .clr(clr),
        .count(count_a), .running(running_a), .done(done_a),
        .error(error_a), .hit(hit_a), .overflow(overflow_a)
    );

    pc_watch_monitor #(.CNTW(8), .AUTOSTART(0)) dut_b (
        .gclk(gclk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_tid(commit_tid),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
        .cfg_mode(cfg_mode), .cfg_tid(cfg_tid), .clr(clr),
        .count(count_b), .running(running_b), .done(done_b),
        .error(error_b), .hit(hit_b), .overflow(overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        commit_valid = 1'b0;
        commit_pc    = '0;
        commit_tid   = '0;
        cfg_we       = 1'b0;
        cfg_idx      = '0;
        cfg_pc       = '0;
        cfg_mode     = '0;
        cfg_tid      = '0;
        clr          = 1'b0;
    endtask

    task automatic commit(input logic [29:0] pc, input logic [5:0] tid);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_tid   = tid;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic wcfg(input logic [1:0] idx, input logic [29:0] pc,
                        input logic [1:0] mode, input logic [5:0] tid);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_pc   = pc;
        cfg_mode = mode;
        cfg_tid  = tid;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  idx;
        logic [29:0] cpc;
        logic [1:0]  mode;
        logic        cv;
        logic [29:0] pc;
        logic [7:0]  cnt;
        logic        run;
        logic        dn;
        logic        err;
        logic [3:0]  hit;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic we, logic [1:0] idx, logic [29:0] cpc,
                                logic [1:0] mode, logic cv, logic [29:0] pc,
                                logic [7:0] cnt, logic run, logic dn,
                                logic err, logic [3:0] hit);
        vec_t v;
        v.we = we; v.idx = idx; v.cpc = cpc; v.mode = mode;
        v.cv = cv; v.pc = pc; v.cnt = cnt; v.run = run;
        v.dn = dn; v.err = err; v.hit = hit;
        return v;
    endfunction

    initial begin
        quiet();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst count_a", count_a, 0);
        chk("rst running_a", running_a, 1);
        chk("rst done_a", done_a, 0);
        chk("rst error_a", error_a, 0);
        chk("rst hit_a", hit_a, 0);
        chk("rst overflow_a", overflow_a, 0);
        chk("rst running_b", running_b, 0);

        // AUTOSTART run stopped by watch0
        wcfg(2'd0, PC_STOP0, 2'd2, 6'd0);
        for (int i = 0; i < 100; i++) commit(30'h100 + 30'(i), 6'd0);
        chk("pre-stop count_a", count_a, 100);
        chk("pre-stop done_a", done_a, 0);
        commit(PC_STOP0, 6'd0);
        chk("stop done_a", done_a, 1);
        chk("stop running_a", running_a, 0);
        chk("stop count_a", count_a, 101);
        chk("stop hit_a", hit_a, 4'b0001);
        for (int i = 0; i < 5; i++) commit(30'h200 + 30'(i), 6'd0);
        chk("post-stop count_a", count_a, 101);
        chk("idle count_b", count_b, 0);
        chk("idle running_b", running_b, 0);
        chk("idle done_b", done_b, 0);

        do_clr();
        chk("clr count_a", count_a, 0);
        chk("clr running_a", running_a, 1);
        chk("clr done_a", done_a, 0);
        chk("clr hit_a", hit_a, 0);

        // Start/stop/error table on the AUTOSTART=0 instance
        tv.push_back(mk(1, 2'd1, PC_START, 2'd1, 0, 30'h0, 0, 0, 0, 0, 4'b0000));
        tv.push_back(mk(1, 2'd2, PC_STOP,  2'd2, 0, 30'h0, 0, 0, 0, 0, 4'b0000));
        tv.push_back(mk(1, 2'd3, PC_ERR,   2'd3, 0, 30'h0, 0, 0, 0, 0, 4'b0000));
        tv.push_back(mk(1, 2'd0, 30'h0,    2'd0, 0, 30'h0, 0, 0, 0, 0, 4'b0000));
        tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 0, PC_START, 0, 0, 0, 0, 4'b0000));
        for (int k = 0; k < 5; k++)
            tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, 30'h10 + 30'(k),
                            0, 0, 0, 0, 4'b0000));
        tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, PC_START, 1, 1, 0, 0, 4'b0010));
        tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, PC_ERR,   2, 1, 0, 1, 4'b1010));
        for (int k = 0; k < 8; k++)
            tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, 30'h20 + 30'(k),
                            8'(3 + k), 1, 0, 1, 4'b1010));
        tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, PC_STOP,  11, 0, 1, 1, 4'b1110));
        tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, 30'h30,   11, 0, 1, 1, 4'b1110));
        tv.push_back(mk(0, 2'd0, 30'h0, 2'd0, 1, PC_START, 11, 0, 1, 1, 4'b1110));

        foreach (tv[k]) begin
            cfg_we       = tv[k].we;
            cfg_idx      = tv[k].idx;
            cfg_pc       = tv[k].cpc;
            cfg_mode     = tv[k].mode;
            commit_valid = tv[k].cv;
            commit_pc    = tv[k].pc;
            step();
            chk($sformatf("v%0d count_b", k), count_b, tv[k].cnt);
            chk($sformatf("v%0d running_b", k), running_b, tv[k].run);
            chk($sformatf("v%0d done_b", k), done_b, tv[k].dn);
            chk($sformatf("v%0d error_b", k), error_b, tv[k].err);
            chk($sformatf("v%0d hit_b", k), hit_b, tv[k].hit);
        end
        quiet();

        // Saturation on the 8-bit counter
        do_clr();
        commit(PC_START, 6'd0);
        for (int i = 0; i < 254; i++) commit(30'h40 + 30'(i), 6'd0);
        chk("sat edge count_b", count_b, 255);
        chk("sat edge overflow_b", overflow_b, 0);
        commit(30'h3F, 6'd0);
        chk("sat count_b", count_b, 255);
        chk("sat overflow_b", overflow_b, 1);
        for (int i = 0; i < 44; i++) commit(30'h140 + 30'(i), 6'd0);
        chk("sat hold count_b", count_b, 255);
        chk("sat running_b", running_b, 1);
        clr = 1'b1;
        commit(PC_START, 6'd0);
        clr = 1'b0;
        chk("clr+commit count_b", count_b, 0);
        chk("clr+commit overflow_b", overflow_b, 0);
        chk("clr+commit running_b", running_b, 0);
        chk("clr+commit hit_b", hit_b, 0);
        chk("clr+commit count_a", count_a, 0);
        chk("clr+commit running_a", running_a, 1);

        // Config write and commit in the same cycle
        cfg_we   = 1'b1;
        cfg_idx  = 2'd0;
        cfg_pc   = PC_NEW;
        cfg_mode = 2'd2;
        commit(PC_NEW, 6'd0);
        quiet();
        chk("same-cycle done_a", done_a, 0);
        chk("same-cycle count_a", count_a, 1);
        chk("same-cycle hit_a", hit_a, 0);
        commit(PC_NEW, 6'd0);
        chk("next-cycle done_a", done_a, 1);
        chk("next-cycle count_a", count_a, 2);
        chk("next-cycle hit_a", hit_a, 4'b0001);

        // Asynchronous reset mid-run drops the configuration
        rst = 1'b1;
        #2;
        chk("async rst count_a", count_a, 0);
        chk("async rst done_a", done_a, 0);
        chk("async rst running_a", running_a, 1);
        rst = 1'b0;
        commit(PC_NEW, 6'd0);
        chk("cfg lost done_a", done_a, 0);
        chk("cfg lost count_a", count_a, 1);

        // Thread filter
        wcfg(2'd0, PC_TID, 2'd2, 6'd3);
        commit(PC_TID, 6'd2);
        chk("tid2 count_a", count_a, 2);
`ifdef PCMON_TID_FILTER_EN
        chk("tid2 done_a", done_a, 0);
        chk("tid2 hit_a", hit_a, 0);
        commit(PC_TID, 6'd3);
        chk("tid3 done_a", done_a, 1);
        chk("tid3 count_a", count_a, 3);
`else
        chk("tid2 done_a", done_a, 1);
        chk("tid2 hit_a", hit_a, 4'b0001);
        commit(PC_TID, 6'd3);
        chk("tid3 done_a", done_a, 1);
        chk("tid3 count_a", count_a, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
